// File: rtl/audio_codec_pkg.sv
// rtl/audio_codec_pkg.sv - shared state encodings and defaults for the I2S codec port
package audio_codec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2
    } i2s_state_t;

    localparam int I2S_DELAY          = 1;
    localparam int DEFAULT_DATA_WIDTH = 24;
    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/audio_frame_fifo.sv
// rtl/audio_frame_fifo.sv - synchronous first-word-fall-through FIFO for stereo frames
module audio_frame_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/audio_codec_port.sv
// rtl/audio_codec_port.sv - I2S codec endpoint: ADC deserializer and DAC serializer around frame FIFOs
module audio_codec_port
    import audio_codec_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  aud_bclk,
    input  logic                  aud_adclrck,
    input  logic                  aud_adcdat,
    input  logic                  aud_daclrck,
    output logic                  aud_dacdat,
    input  logic                  read_ena,
    output logic                  read_ready,
    output logic [DATA_WIDTH-1:0] readdata_left,
    output logic [DATA_WIDTH-1:0] readdata_right,
    input  logic                  write_ena,
    output logic                  write_ready,
    input  logic [DATA_WIDTH-1:0] writedata_left,
    input  logic [DATA_WIDTH-1:0] writedata_right,
    output logic                  overflow,
    output logic                  underrun
);
    localparam int FW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_DW    = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] SKIP_LAST = CW'(I2S_DELAY - 1);

    logic [1:0] r_bclk_sync, r_adclr_sync, r_adcdat_sync, r_daclr_sync;
    logic       r_bclk_prev;
    logic       r_adc_lr, r_adc_lr_vld, r_dac_lr, r_dac_lr_vld;
    logic       w_bclk_rise, w_bclk_fall, w_adcdat;
    logic       w_adc_edge, w_dac_edge, w_dac_edge_fall, w_dac_edge_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bclk_sync   <= '0;
            r_adclr_sync  <= '0;
            r_adcdat_sync <= '0;
            r_daclr_sync  <= '0;
            r_bclk_prev   <= 1'b0;
            r_adc_lr      <= 1'b0;
            r_adc_lr_vld  <= 1'b0;
            r_dac_lr      <= 1'b0;
            r_dac_lr_vld  <= 1'b0;
        end else begin
            r_bclk_sync   <= {r_bclk_sync[0], aud_bclk};
            r_adclr_sync  <= {r_adclr_sync[0], aud_adclrck};
            r_adcdat_sync <= {r_adcdat_sync[0], aud_adcdat};
            r_daclr_sync  <= {r_daclr_sync[0], aud_daclrck};
            r_bclk_prev   <= r_bclk_sync[1];
            if (w_bclk_rise) begin
                r_adc_lr     <= r_adclr_sync[1];
                r_adc_lr_vld <= 1'b1;
                r_dac_lr     <= r_daclr_sync[1];
                r_dac_lr_vld <= 1'b1;
            end
        end
    end

    assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_prev;
    assign w_bclk_fall = ~r_bclk_sync[1] & r_bclk_prev;
    assign w_adcdat    = r_adcdat_sync[1];
    // The first LRCK sample after reset only seeds the history; it is never an edge.
    assign w_adc_edge      = w_bclk_rise & r_adc_lr_vld & (r_adclr_sync[1] != r_adc_lr);
    assign w_dac_edge_fall = w_bclk_rise & r_dac_lr_vld & r_dac_lr & ~r_daclr_sync[1];
    assign w_dac_edge_rise = w_bclk_rise & r_dac_lr_vld & ~r_dac_lr & r_daclr_sync[1];
    assign w_dac_edge      = w_dac_edge_fall | w_dac_edge_rise;

    i2s_state_t            r_rx_state, w_rx_next;
    logic [CW-1:0]         r_rx_cnt;
    logic [DATA_WIDTH-1:0] r_rx_left, r_rx_right;
    logic                  w_rx_cnt_clr, w_rx_cnt_inc, w_rx_cap, w_rx_push;
    logic [FW-1:0]         w_rx_frame, w_rx_rdata;
    logic                  w_rx_full, w_rx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= ST_IDLE;
        end else begin
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            ST_IDLE:  if (w_adc_edge) w_rx_next = ST_SKIP;
            ST_SKIP:  if (w_adc_edge) w_rx_next = ST_SKIP;
                      else if (w_bclk_rise && r_rx_cnt == SKIP_LAST) w_rx_next = ST_SHIFT;
            ST_SHIFT: if (w_adc_edge) w_rx_next = ST_SKIP;
            default:  w_rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rx_cnt_clr = (w_rx_next != r_rx_state) || w_adc_edge;
        w_rx_cap     = (r_rx_state == ST_SHIFT) && w_bclk_rise && !w_adc_edge && (r_rx_cnt != CNT_DW);
        w_rx_cnt_inc = w_bclk_rise && !w_rx_cnt_clr && ((r_rx_state == ST_SKIP) || w_rx_cap);
        w_rx_push    = w_rx_cap && r_adc_lr && (r_rx_cnt == CNT_DW - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt   <= '0;
            r_rx_left  <= '0;
            r_rx_right <= '0;
            overflow   <= 1'b0;
        end else begin
            if (w_rx_cnt_clr) begin
                r_rx_cnt <= '0;
            end else if (w_rx_cnt_inc) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            if (w_rx_cap && r_adc_lr) begin
                r_rx_right <= {r_rx_right[DATA_WIDTH-2:0], w_adcdat};
            end else if (w_rx_cap) begin
                r_rx_left <= {r_rx_left[DATA_WIDTH-2:0], w_adcdat};
            end
            if (w_rx_push && w_rx_full && !read_ena) begin
                overflow <= 1'b1;
            end
        end
    end

    assign w_rx_frame = {r_rx_left, r_rx_right[DATA_WIDTH-2:0], w_adcdat};

    audio_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_rx_push),
        .i_wdata (w_rx_frame),
        .i_pop   (read_ena),
        .o_rdata (w_rx_rdata),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign read_ready     = !w_rx_empty;
    assign readdata_left  = w_rx_rdata[FW-1:DATA_WIDTH];
    assign readdata_right = w_rx_rdata[DATA_WIDTH-1:0];

    i2s_state_t    r_tx_state, w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [FW-1:0] r_tx_sr, w_tx_rdata;
    logic          r_dacdat;
    logic          w_tx_cnt_clr, w_tx_cnt_inc, w_tx_drive, w_tx_full, w_tx_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= ST_IDLE;
        end else begin
            r_tx_state <= w_tx_next;
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            ST_IDLE:  if (w_dac_edge_fall) w_tx_next = ST_SKIP;
            ST_SKIP:  if (w_dac_edge) w_tx_next = ST_SKIP;
                      else if (w_bclk_fall && r_tx_cnt == SKIP_LAST) w_tx_next = ST_SHIFT;
            ST_SHIFT: if (w_dac_edge) w_tx_next = ST_SKIP;
            default:  w_tx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_cnt_clr = (w_tx_next != r_tx_state) || w_dac_edge;
        w_tx_drive   = (r_tx_state == ST_SHIFT) && w_bclk_fall && (r_tx_cnt != CNT_DW);
        w_tx_cnt_inc = w_bclk_fall && !w_tx_cnt_clr && ((r_tx_state == ST_SKIP) || w_tx_drive);
    end

    // Left half shifts out exactly DATA_WIDTH bits, leaving the right sample at the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_cnt <= '0;
            r_tx_sr  <= '0;
            r_dacdat <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (w_tx_cnt_clr) begin
                r_tx_cnt <= '0;
            end else if (w_tx_cnt_inc) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            if (w_dac_edge_fall) begin
                r_tx_sr <= w_tx_empty ? '0 : w_tx_rdata;
                if (w_tx_empty) begin
                    underrun <= 1'b1;
                end
            end else if (w_tx_drive) begin
                r_tx_sr <= {r_tx_sr[FW-2:0], 1'b0};
            end
            if (w_bclk_fall) begin
                r_dacdat <= w_tx_drive ? r_tx_sr[FW-1] : 1'b0;
            end
        end
    end

    audio_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (write_ena),
        .i_wdata ({writedata_left, writedata_right}),
        .i_pop   (w_dac_edge_fall),
        .o_rdata (w_tx_rdata),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign write_ready = !w_tx_full;
    assign aud_dacdat  = r_dacdat;

endmodule

// File: tb/tb_audio_codec_port.sv
// tb/tb_audio_codec_port.sv - self-checking bench for audio_codec_port with a frame-level model
module tb_audio_codec_port;
    localparam int DW    = 24;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          aud_bclk = 1'b0, aud_adclrck = 1'b0, aud_adcdat = 1'b0, aud_daclrck = 1'b0;
    logic          aud_dacdat;
    logic          read_ena = 1'b0, read_ready;
    logic [DW-1:0] readdata_left, readdata_right;
    logic          write_ena = 1'b0, write_ready;
    logic [DW-1:0] writedata_left = '0, writedata_right = '0;
    logic          overflow, underrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*DW-1:0] q_rx[$];
    logic [2*DW-1:0] q_tx[$];
    logic            m_ovf = 1'b0;
    logic            m_und = 1'b0;

    always #5 clk = ~clk;

    audio_codec_port #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .aud_bclk        (aud_bclk),
        .aud_adclrck     (aud_adclrck),
        .aud_adcdat      (aud_adcdat),
        .aud_daclrck     (aud_daclrck),
        .aud_dacdat      (aud_dacdat),
        .read_ena        (read_ena),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .write_ena       (write_ena),
        .write_ready     (write_ready),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .overflow        (overflow),
        .underrun        (underrun)
    );

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk24(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One BCLK period (8 clk); the DAC line is sampled where the codec would, at the rising edge.
    task automatic slot(input logic lr, input logic dat, output logic dac);
        @(negedge clk);
        aud_bclk = 1'b0; aud_adclrck = lr; aud_daclrck = lr; aud_adcdat = dat;
        repeat (3) @(negedge clk);
        @(negedge clk);
        dac = aud_dacdat;
        aud_bclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        q_rx.delete(); q_tx.delete();
        m_ovf = 1'b0; m_und = 1'b0;
    endtask

    task automatic align();
        logic s;
        for (int k = 0; k < 8; k++) slot(k >= 4, 1'b0, s);
    endtask

    // 64-slot frame: half-frame edge slot, one delay slot, 24 data slots MSB first, 6 pad slots.
    task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int abort_at,
                         output logic [DW-1:0] dl, output logic [DW-1:0] dr);
        logic [2*DW-1:0] exp_tx;
        logic            s;
        int              pad_ones;
        dl = '0; dr = '0; pad_ones = 0; exp_tx = '0;
        if (q_tx.size() > 0) exp_tx = q_tx.pop_front();
        else m_und = 1'b1;
        for (int k = 0; k < 64; k++) begin
            int            p;
            logic [DW-1:0] w;
            logic          b;
            p = k % 32;
            w = (k < 32) ? l : r;
            b = (p >= 2 && p < 26) ? w[25-p] : 1'b0;
            if (k == abort_at) begin
                do_reset();
                return;
            end
            slot(k >= 32, b, s);
            if (p >= 2 && p < 26) begin
                if (k < 32) dl[25-p] = s;
                else dr[25-p] = s;
            end else if (s) begin
                pad_ones++;
            end
            if (k == 56) chk1("read_ready_before_lsb", read_ready, q_rx.size() > 0);
            if (k == 57) begin
                if (q_rx.size() < DEPTH) q_rx.push_back({l, r});
                else m_ovf = 1'b1;
                chk1("read_ready_after_lsb", read_ready, q_rx.size() > 0);
            end
        end
        chk24("dac_left", dl, exp_tx[2*DW-1:DW]);
        chk24("dac_right", dr, exp_tx[DW-1:0]);
        chk1("dac_pad_zero", pad_ones == 0, 1'b1);
        chk1("overflow", overflow, m_ovf);
        chk1("underrun", underrun, m_und);
        chk1("write_ready_frame", write_ready, q_tx.size() < DEPTH);
    endtask

    task automatic push_tx(input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(negedge clk);
        chk1("write_ready", write_ready, q_tx.size() < DEPTH);
        if (q_tx.size() < DEPTH) q_tx.push_back({l, r});
        writedata_left = l; writedata_right = r; write_ena = 1'b1;
        @(negedge clk);
        write_ena = 1'b0;
    endtask

    task automatic pop_rx();
        logic [2*DW-1:0] head;
        @(negedge clk);
        chk1("read_ready", read_ready, q_rx.size() > 0);
        if (q_rx.size() > 0) begin
            head = q_rx.pop_front();
            chk24("readdata_left", readdata_left, head[2*DW-1:DW]);
            chk24("readdata_right", readdata_right, head[DW-1:0]);
        end
        read_ena = 1'b1;
        @(negedge clk);
        read_ena = 1'b0;
        chk1("read_ready_after_pop", read_ready, q_rx.size() > 0);
    endtask

    typedef struct {
        logic [DW-1:0] adc_l, adc_r;
        logic          push;
        logic [DW-1:0] tx_l, tx_r;
        logic [DW-1:0] exp_l, exp_r;
        logic          exp_und;
    } vec_t;

    initial begin
        vec_t          tbl[4];
        logic [DW-1:0] dl, dr;

        tbl[0] = '{24'hA5A5A5, 24'h5A5A5A, 1'b1, 24'h800001, 24'h7FFFFF, 24'h800001, 24'h7FFFFF, 1'b0};
        tbl[1] = '{24'h123456, 24'hFEDCBA, 1'b0, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 1'b1};
        tbl[2] = '{24'h000001, 24'h800000, 1'b1, 24'hABCDEF, 24'h135790, 24'hABCDEF, 24'h135790, 1'b1};
        tbl[3] = '{24'hFFFFFF, 24'h000000, 1'b1, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000001, 1'b1};

        do_reset();
        @(negedge clk);
        chk1("reset_read_ready", read_ready, 1'b0);
        chk1("reset_write_ready", write_ready, 1'b1);
        chk24("reset_readdata_left", readdata_left, 24'h0);
        chk24("reset_readdata_right", readdata_right, 24'h0);
        chk1("reset_overflow", overflow, 1'b0);
        chk1("reset_underrun", underrun, 1'b0);
        chk1("reset_dacdat", aud_dacdat, 1'b0);

        align();
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].push) push_tx(tbl[i].tx_l, tbl[i].tx_r);
            frame(tbl[i].adc_l, tbl[i].adc_r, -1, dl, dr);
            chk24("tbl_dac_left", dl, tbl[i].exp_l);
            chk24("tbl_dac_right", dr, tbl[i].exp_r);
            chk1("tbl_underrun", underrun, tbl[i].exp_und);
            chk24("tbl_readdata_left", readdata_left, tbl[i].adc_l);
            chk24("tbl_readdata_right", readdata_right, tbl[i].adc_r);
            pop_rx();
        end

        // Overflow: five frames with no reads; only the first four survive.
        for (int i = 0; i < 5; i++) begin
            frame(24'h100000 + 24'(i), 24'h200000 + 24'(i), -1, dl, dr);
            chk1("overflow_progress", overflow, i == 4);
        end
        for (int i = 0; i < 4; i++) pop_rx();
        chk1("overflow_sticky", overflow, 1'b1);

        // Backpressure: the fifth push is ignored; one frame load reopens the FIFO.
        for (int i = 0; i < 5; i++) push_tx(24'h300000 + 24'(i), 24'h400000 + 24'(i));
        chk1("write_ready_full", write_ready, 1'b0);
        frame(24'h0F0F0F, 24'hF0F0F0, -1, dl, dr);
        chk24("backpressure_first_left", dl, 24'h300000);
        chk1("write_ready_reopen", write_ready, 1'b1);

        for (int it = 0; it < 8; it++) begin
            int n_push, n_pop;
            n_push = int'($urandom_range(0, 2));
            n_pop  = int'($urandom_range(0, 2));
            for (int j = 0; j < n_push; j++) push_tx(24'($urandom()), 24'($urandom()));
            frame(24'($urandom()), 24'($urandom()), -1, dl, dr);
            for (int j = 0; j < n_pop; j++) pop_rx();
        end

        // Reset mid-frame with two RX frames queued, then a clean frame after re-alignment.
        while (q_rx.size() > 0) pop_rx();
        for (int j = 0; j < 3; j++) push_tx(24'($urandom()), 24'($urandom()));
        frame(24'h111111, 24'h222222, -1, dl, dr);
        frame(24'h333333, 24'h444444, -1, dl, dr);
        frame(24'h555555, 24'h666666, 12, dl, dr);
        @(negedge clk);
        chk1("midreset_read_ready", read_ready, 1'b0);
        chk1("midreset_write_ready", write_ready, 1'b1);
        chk1("midreset_overflow", overflow, 1'b0);
        chk1("midreset_underrun", underrun, 1'b0);
        align();
        frame(24'hC0FFEE, 24'hBEEF01, -1, dl, dr);
        chk24("post_reset_left", readdata_left, 24'hC0FFEE);
        chk24("post_reset_right", readdata_right, 24'hBEEF01);
        pop_rx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_codec_port.md
Name: audio_codec_port

Overview:
- Codec-side endpoint of the sample-path handshake: produces `read_ready`/`write_ready`, consumes `read_ena`/`write_ena` from the datapath control unit.
- Deserializes I2S ADC stereo frames from the audio codec into an input FIFO.
- Serializes stereo frames from an output FIFO onto the I2S DAC line.
- Sits between codec pins (codec is bit-clock/LR-clock master) and the processing datapath.

Parameters:
- DATA_WIDTH, 24, bits per channel sample.
- FIFO_DEPTH, 4, stereo frames per FIFO; power of 2, at least 2.

Ports:
- clk  in  1  system clock; all logic on posedge; at least 4x aud_bclk.
- reset  in  1  reset, synchronous, active-high.
- aud_bclk  in  1  codec bit clock, asynchronous.
- aud_adclrck  in  1  ADC LR clock, async; 0 = left, 1 = right.
- aud_adcdat  in  1  ADC serial data, async.
- aud_daclrck  in  1  DAC LR clock, async; 0 = left, 1 = right.
- aud_dacdat  out  1  DAC serial data.
- read_ena  in  1  pop one frame from input FIFO.
- read_ready  out  1  input FIFO not empty.
- readdata_left  out  DATA_WIDTH  head frame, left channel; first-word-fall-through.
- readdata_right  out  DATA_WIDTH  head frame, right channel.
- write_ena  in  1  push one frame into output FIFO.
- write_ready  out  1  output FIFO not full.
- writedata_left  in  DATA_WIDTH  left sample to push.
- writedata_right  in  DATA_WIDTH  right sample to push.
- overflow  out  1  sticky: ADC frame dropped because input FIFO full.
- underrun  out  1  sticky: DAC frame started with output FIFO empty.

Behaviour:
- Clock and reset: reset, synchronous, active-high; clock clk.
- Reset values: aud_dacdat=0, read_ready=0, write_ready=1, readdata_*=0, overflow=0, underrun=0. Both FIFOs are empty, bit counters are idle, and shift registers are 0.
- Synchronization:
  - aud_bclk, aud_adclrck, aud_adcdat and aud_daclrck each pass through 2-FF synchronizers.
  - bclk_rise and bclk_fall are single-cycle strobes from the synchronized bclk compared with its previous value.
  - LRCK values are sampled only on bclk_rise.
- RX FSM, states IDLE, SKIP, SHIFT:
  - IDLE: stay until an ADC LRCK transition is seen on bclk_rise; this aligns to the first full half-frame after reset.
  - SKIP: the one-BCLK I2S delay; ignore the next bclk_rise.
  - SHIFT: capture aud_adcdat MSB-first on bclk_rise for DATA_WIDTH bits, into the left register when LRCK=0 and the right register when LRCK=1. Bits after DATA_WIDTH are ignored until the next LRCK edge.
  - Any LRCK edge while in SHIFT returns the FSM to SKIP, which re-aligns a short frame.
  - Push: when the right channel completes, push {left,right} in the same cycle. If the FIFO is full, drop the frame, set overflow, and leave FIFO contents untouched.
- TX FSM, states IDLE, SKIP, SHIFT:
  - IDLE: wait for a DAC LRCK 1->0 edge on bclk_rise.
  - Frame load on the 1->0 edge: if the output FIFO is not empty, pop one frame into a 2*DATA_WIDTH shift register. If it is empty, load zeros and set underrun.
  - On a DAC LRCK 0->1 edge, the right half begins; the register already holds it.
  - After each LRCK edge, skip one bclk_fall. Then on each bclk_fall drive the next bit MSB-first for DATA_WIDTH bits, and drive 0 after that.
- Handshake rules:
  - read_ena while read_ready=0 is ignored.
  - write_ena while write_ready=0 is ignored; no overwrite.
  - read_ena and write_ena are single-cycle pops/pushes. Holding either high pops or pushes every cycle.
  - FIFO flags update one cycle after the operation.
  - readdata reflects the new head in the cycle after a pop.
- Simultaneous events:
  - RX push and read_ena pop in the same cycle: both occur and count is unchanged. If the FIFO was full, the pop frees space and the push succeeds.
  - The same rule applies to write_ena and a TX load on the output FIFO.
- Pointers wrap modulo FIFO_DEPTH. Occupancy uses a count of width log2(FIFO_DEPTH)+1.
- Reset mid-frame abandons partial frames and flushes both FIFOs. Both FSMs re-enter IDLE and wait for a fresh LRCK edge.
- overflow and underrun clear only on reset.

Decomposition:
- Shared package audio_codec_pkg holds:
  - RX/TX state encodings (IDLE=2'd0, SKIP=2'd1, SHIFT=2'd2);
  - I2S_DELAY=1;
  - the default DATA_WIDTH and FIFO_DEPTH.
- One sub-module, audio_frame_fifo: a synchronous FWFT FIFO (WIDTH=2*DATA_WIDTH, DEPTH) with push, pop, full, empty. It is instantiated twice, once for RX and once for TX.

Test Plan:
- RX single frame: bclk=clk/8. Drive left=24'hA5A5A5 and right=24'h5A5A5A in I2S format, preceded by one alignment LRCK edge. Required: read_ready rises after the right LSB plus 3-4 clk; readdata_left=24'hA5A5A5, readdata_right=24'h5A5A5A. A 1-cycle read_ena then drops read_ready the next cycle.
- RX overflow: send 5 frames with no read_ena, FIFO_DEPTH=4. Required: overflow=1 after the 5th frame; the 4 frames read back in order are the first 4; the 5th is lost.
- TX path: push {24'h800001, 24'h7FFFFF} via write_ena before a DAC LRCK 1->0 edge. Required: after one BCLK delay, aud_dacdat carries 1000…0001 on the left half and 0111…1111 on the right half, sampled at bclk_rise; underrun stays 0.
- TX underrun: output FIFO empty at the LRCK 1->0 edge. Required: aud_dacdat=0 for the whole frame and underrun=1. The next pushed frame is serialized on the following frame.
- Backpressure: 4 write_ena pushes. Required: write_ready=0 after the 4th; a 5th write_ena is ignored. After one TX frame load, write_ready=1 again.
- Reset mid-frame: assert reset during RX bit 10 with 2 frames queued. Required: read_ready=0 and the flags are 0. The next complete frame after a fresh LRCK edge is received correctly.
